// File: rtl/perf_engine_sched.sv
`default_nettype none
// ============================================================================
//  Module      : perf_engine_sched
//  Description : Iteration scheduler for the perf-test action. Launches the
//                read and/or write engine once per iteration, waits for every
//                enabled engine to report completion, repeats for the
//                programmed iteration count, counts total run cycles and
//                enforces a per-iteration timeout. Reports done / error status.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, resetn          clock; asynchronous active-low reset
//    cfg_start            one-cycle start pulse (honoured only when idle)
//    cfg_abort            abort request (level)
//    cfg_rd_en/cfg_wr_en  engine participation enables
//    cfg_iter             iterations to run
//    cfg_timeout          per-iteration timeout in cycles (0 = disabled)
//    rd/wr_engine_start   one-cycle launch pulses to the engines
//    rd_done/wr_done      engine iteration-complete pulses
//    data_error           engine data error (level or pulse)
//    busy                 high whenever not idle
//    sched_done           one-cycle completion pulse
//    err_code             00 ok, 01 data error, 10 timeout, 11 abort
//    iter_cnt             completed iterations
//    cycle_cnt            total run cycles (saturating)
//  Optional (macro PERF_SCHED_LATENCY_EN)
//    lat_min / lat_max    min / max WAIT-cycle count per completed iteration
// ============================================================================
module perf_engine_sched #(
    parameter int CNT_W = 32,
    parameter int CYC_W = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_rd_en,
    input  logic             cfg_wr_en,
    input  logic [CNT_W-1:0] cfg_iter,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             rd_engine_start,
    output logic             wr_engine_start,
    input  logic             rd_done,
    input  logic             wr_done,
    input  logic             data_error,
    output logic             busy,
    output logic             sched_done,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] iter_cnt,
`ifdef PERF_SCHED_LATENCY_EN
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
`endif
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_LAUNCH = 6'b000010,
        S_WAIT   = 6'b000100,
        S_CHECK  = 6'b001000,
        S_FINISH = 6'b010000,
        S_ERROR  = 6'b100000
    } state_t;

    localparam logic [1:0] C_ERR_DATA  = 2'b01;
    localparam logic [1:0] C_ERR_TMO   = 2'b10;
    localparam logic [1:0] C_ERR_ABORT = 2'b11;

    state_t             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;
    logic [CNT_W-1:0]   iter_tgt_q, iter_tgt_d;
    logic [CNT_W-1:0]   tmo_tgt_q, tmo_tgt_d;
    logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [1:0]         err_q, err_d;
    logic               rd_seen_q, rd_seen_d;
    logic               wr_seen_q, wr_seen_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
`ifdef PERF_SCHED_LATENCY_EN
    logic [CNT_W-1:0]   lat_min_q, lat_min_d;
    logic [CNT_W-1:0]   lat_max_q, lat_max_d;
`endif

    logic               w_rd_ok;
    logic               w_wr_ok;
    logic               w_hard_err;
    logic [1:0]         w_hard_code;
    logic [CNT_W-1:0]   w_wait_inc;
    logic [CNT_W-1:0]   w_iter_inc;
    logic               w_timeout;
    logic               w_counting;

    // A disabled engine is always complete; an incoming pulse counts in the
    // same cycle it arrives, before it reaches the sticky latch.
    assign w_rd_ok     = ~rd_en_q | rd_seen_q | rd_done;
    assign w_wr_ok     = ~wr_en_q | wr_seen_q | wr_done;
    assign w_hard_err  = cfg_abort | data_error;
    assign w_hard_code = cfg_abort ? C_ERR_ABORT : C_ERR_DATA;
    assign w_wait_inc  = wait_cnt_q + CNT_W'(1);
    assign w_iter_inc  = iter_cnt_q + CNT_W'(1);
    assign w_timeout   = (tmo_tgt_q != '0) && (w_wait_inc == tmo_tgt_q);
    assign w_counting  = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                         (state_q == S_CHECK);

    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        iter_tgt_d  = iter_tgt_q;
        tmo_tgt_d   = tmo_tgt_q;
        iter_cnt_d  = iter_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        err_d       = err_q;
        rd_seen_d   = rd_seen_q;
        wr_seen_d   = wr_seen_q;
        wait_cnt_d  = wait_cnt_q;
`ifdef PERF_SCHED_LATENCY_EN
        lat_min_d   = lat_min_q;
        lat_max_d   = lat_max_q;
`endif

        // Saturating run-cycle counter.
        if (w_counting && !(&cycle_cnt_q)) begin
            cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    rd_en_d     = cfg_rd_en;
                    wr_en_d     = cfg_wr_en;
                    iter_tgt_d  = cfg_iter;
                    tmo_tgt_d   = cfg_timeout;
                    iter_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    err_d       = '0;
`ifdef PERF_SCHED_LATENCY_EN
                    lat_min_d   = '1;
                    lat_max_d   = '0;
`endif
                    if ((cfg_iter == '0) || !(cfg_rd_en || cfg_wr_en)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                rd_seen_d  = 1'b0;
                wr_seen_d  = 1'b0;
                wait_cnt_d = '0;
                if (w_hard_err) begin
                    state_d = S_ERROR;
                    err_d   = w_hard_code;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = w_wait_inc;
                rd_seen_d  = rd_seen_q | (rd_en_q & rd_done);
                wr_seen_d  = wr_seen_q | (wr_en_q & wr_done);
                // Every error source outranks a same-cycle completion.
                if (w_hard_err) begin
                    state_d = S_ERROR;
                    err_d   = w_hard_code;
                end else if (w_timeout) begin
                    state_d = S_ERROR;
                    err_d   = C_ERR_TMO;
                end else if (w_rd_ok && w_wr_ok) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_hard_err) begin
                    state_d = S_ERROR;
                    err_d   = w_hard_code;
                end else begin
                    iter_cnt_d = w_iter_inc;
`ifdef PERF_SCHED_LATENCY_EN
                    // wait_cnt_q holds the WAIT length of the iteration just completed.
                    if (wait_cnt_q < lat_min_q) lat_min_d = wait_cnt_q;
                    if (wait_cnt_q > lat_max_q) lat_max_d = wait_cnt_q;
`endif
                    state_d = (w_iter_inc == iter_tgt_q) ? S_FINISH : S_LAUNCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            iter_tgt_q  <= '0;
            tmo_tgt_q   <= '0;
            iter_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            err_q       <= '0;
            rd_seen_q   <= 1'b0;
            wr_seen_q   <= 1'b0;
            wait_cnt_q  <= '0;
`ifdef PERF_SCHED_LATENCY_EN
            lat_min_q   <= '0;
            lat_max_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            iter_tgt_q  <= iter_tgt_d;
            tmo_tgt_q   <= tmo_tgt_d;
            iter_cnt_q  <= iter_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_q       <= err_d;
            rd_seen_q   <= rd_seen_d;
            wr_seen_q   <= wr_seen_d;
            wait_cnt_q  <= wait_cnt_d;
`ifdef PERF_SCHED_LATENCY_EN
            lat_min_q   <= lat_min_d;
            lat_max_q   <= lat_max_d;
`endif
        end
    end

    // Moore outputs: decoded directly from registered state.
    assign busy            = (state_q != S_IDLE);
    assign sched_done      = (state_q == S_FINISH) || (state_q == S_ERROR);
    assign rd_engine_start = (state_q == S_LAUNCH) && rd_en_q;
    assign wr_engine_start = (state_q == S_LAUNCH) && wr_en_q;
    assign err_code        = err_q;
    assign iter_cnt        = iter_cnt_q;
    assign cycle_cnt       = cycle_cnt_q;
`ifdef PERF_SCHED_LATENCY_EN
    assign lat_min         = lat_min_q;
    assign lat_max         = lat_max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_perf_engine_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_engine_sched
//  Description : Self-checking bench for perf_engine_sched. Engine responders
//                are emulated cycle by cycle; expected results come from
//                directed constants and an iteration-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_engine_sched;
    localparam int CNT_W = 32;
    localparam int CYC_W = 64;

    logic             clk = 1'b0;
    logic             resetn;
    logic             cfg_start, cfg_abort, cfg_rd_en, cfg_wr_en;
    logic [CNT_W-1:0] cfg_iter, cfg_timeout;
    logic             rd_engine_start, wr_engine_start;
    logic             rd_done, wr_done, data_error;
    logic             busy, sched_done;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] iter_cnt;
    logic [CYC_W-1:0] cycle_cnt;
`ifdef PERF_SCHED_LATENCY_EN
    logic [CNT_W-1:0] lat_min, lat_max;
`endif

    always #5 clk = ~clk;

    perf_engine_sched #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en),
        .cfg_iter(cfg_iter), .cfg_timeout(cfg_timeout),
        .rd_engine_start(rd_engine_start), .wr_engine_start(wr_engine_start),
        .rd_done(rd_done), .wr_done(wr_done), .data_error(data_error),
        .busy(busy), .sched_done(sched_done), .err_code(err_code),
        .iter_cnt(iter_cnt),
`ifdef PERF_SCHED_LATENCY_EN
        .lat_min(lat_min), .lat_max(lat_max),
`endif
        .cycle_cnt(cycle_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Scenario description (shared by driver and model)
    bit c_rd_en, c_wr_en;
    int c_iter, c_tmo;
    int rd_d[8];   // per-iteration done delay after launch; 0 = never
    int wr_d[8];
    int f_kind;    // 0 none, 1 data_error, 2 abort
    int f_iter, f_cyc, spur_cyc;

    // Observed
    int obs_rd, obs_wr, obs_done_cnt, obs_done_cyc, obs_busy_after;
    logic [1:0]       obs_err;
    logic [CNT_W-1:0] obs_iter;
    logic [CYC_W-1:0] obs_cyc;

    // Expected
    int exp_rd, exp_wr, exp_iter, exp_err;
    longint exp_cyc;
    logic [CNT_W-1:0] exp_lat_min, exp_lat_max;

    // Iteration-level model: each iteration costs launch + W waits + check,
    // unless an error lands first.
    function automatic void compute_expected();
        int w, e, code;
        bit never;
        exp_rd = 0; exp_wr = 0; exp_iter = 0; exp_err = 0; exp_cyc = 0;
        exp_lat_min = '1; exp_lat_max = '0;
        if (c_iter != 0 && (c_rd_en || c_wr_en)) begin
            for (int i = 0; i < c_iter; i++) begin
                exp_rd += int'(c_rd_en);
                exp_wr += int'(c_wr_en);
                w = 0; never = 0;
                if (c_rd_en) begin if (rd_d[i] == 0) never = 1; else if (rd_d[i] > w) w = rd_d[i]; end
                if (c_wr_en) begin if (wr_d[i] == 0) never = 1; else if (wr_d[i] > w) w = wr_d[i]; end
                if (never) w = 1000000;
                e = 1000000; code = 0;
                if (c_tmo != 0) begin e = c_tmo; code = 2; end
                if (f_kind != 0 && f_iter == i && f_cyc <= e) begin
                    e = f_cyc; code = (f_kind == 1) ? 1 : 3;
                end
                if (e <= w) begin exp_cyc += 1 + e; exp_err = code; break; end
                if (f_kind != 0 && f_iter == i && f_cyc == w + 1) begin
                    exp_cyc += w + 2; exp_err = (f_kind == 1) ? 1 : 3; break;
                end
                exp_cyc += w + 2;
                exp_iter++;
                if (32'(w) < exp_lat_min) exp_lat_min = 32'(w);
                if (32'(w) > exp_lat_max) exp_lat_max = 32'(w);
            end
        end
    endfunction

    // Runs one scheduler job while emulating the engines; records observations.
    task automatic drive_run();
        int rd_left, wr_left, launch_idx, since, tail;
        bit seen;
        @(negedge clk);
        cfg_rd_en = c_rd_en; cfg_wr_en = c_wr_en;
        cfg_iter = 32'(c_iter); cfg_timeout = 32'(c_tmo); cfg_start = 1'b1;
        obs_rd = 0; obs_wr = 0; obs_done_cnt = 0; obs_done_cyc = -1; obs_busy_after = -1;
        rd_left = -1; wr_left = -1; launch_idx = -1; since = 0; tail = 0; seen = 0;
        for (int cyc = 1; cyc <= 3000 && tail < 3; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
            data_error = 1'b0; cfg_abort = 1'b0;
            if (seen) begin
                if (tail == 0) obs_busy_after = int'(busy);
                tail++;
            end
            if (sched_done) begin
                obs_done_cnt++;
                if (!seen) obs_done_cyc = cyc;
                seen = 1;
            end
            if (rd_engine_start) obs_rd++;
            if (wr_engine_start) obs_wr++;
            if (rd_engine_start || wr_engine_start) begin
                launch_idx++; since = 0;
                rd_left = (rd_engine_start && launch_idx < 8 && rd_d[launch_idx] != 0) ? rd_d[launch_idx] : -1;
                wr_left = (wr_engine_start && launch_idx < 8 && wr_d[launch_idx] != 0) ? wr_d[launch_idx] : -1;
            end else begin
                since++;
                if (rd_left > 0) begin rd_left--; if (rd_left == 0) begin rd_done = 1'b1; rd_left = -1; end end
                if (wr_left > 0) begin wr_left--; if (wr_left == 0) begin wr_done = 1'b1; wr_left = -1; end end
            end
            // Disabled engines chatter on their done lines; must be ignored.
            if (!c_rd_en) rd_done = 1'($urandom_range(0, 1));
            if (!c_wr_en) wr_done = 1'($urandom_range(0, 1));
            if (f_kind != 0 && launch_idx == f_iter && since == f_cyc) begin
                if (f_kind == 1) data_error = 1'b1; else cfg_abort = 1'b1;
            end
            if (cyc == spur_cyc) begin
                cfg_start = 1'b1; cfg_iter = 32'd7; cfg_rd_en = 1'b1; cfg_wr_en = 1'b1;
            end
        end
        @(negedge clk);
        rd_done = 1'b0; wr_done = 1'b0; cfg_start = 1'b0;
        obs_err = err_code; obs_iter = iter_cnt; obs_cyc = cycle_cnt;
    endtask

    task automatic clear_scenario();
        c_rd_en = 0; c_wr_en = 0; c_iter = 0; c_tmo = 0;
        f_kind = 0; f_iter = -1; f_cyc = -1; spur_cyc = -1;
        for (int i = 0; i < 8; i++) begin rd_d[i] = 1; wr_d[i] = 1; end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        cfg_start = 0; cfg_abort = 0; cfg_rd_en = 0; cfg_wr_en = 0;
        cfg_iter = '0; cfg_timeout = '0; rd_done = 0; wr_done = 0; data_error = 0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, sched_done, rd_engine_start, wr_engine_start} !== 4'b0) begin errors++;
            $display("FAIL reset_ctrl got %b expected 0000", {busy, sched_done, rd_engine_start, wr_engine_start}); end
        checks++; if ({err_code, iter_cnt, cycle_cnt} !== '0) begin errors++;
            $display("FAIL reset_cnt got err=%0d iter=%0d cyc=%0d expected all 0", err_code, iter_cnt, cycle_cnt); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_rd();
        clear_scenario();
        c_rd_en = 1; c_iter = 3; rd_d[0] = 5; rd_d[1] = 5; rd_d[2] = 5;
        drive_run();
        checks++; if (obs_rd !== 3 || obs_wr !== 0) begin errors++;
            $display("FAIL single_starts got rd=%0d wr=%0d expected rd=3 wr=0", obs_rd, obs_wr); end
        checks++; if (obs_iter !== 32'd3) begin errors++;
            $display("FAIL single_iter got %0d expected 3", obs_iter); end
        checks++; if (obs_cyc !== 64'd21) begin errors++;
            $display("FAIL single_cycles got %0d expected 21", obs_cyc); end
        checks++; if (obs_err !== 2'b00 || obs_done_cnt !== 1 || obs_done_cyc !== 22) begin errors++;
            $display("FAIL single_done got err=%0d dones=%0d at=%0d expected 0/1/22", obs_err, obs_done_cnt, obs_done_cyc); end
    endtask

    task automatic test_dual();
        clear_scenario();
        c_rd_en = 1; c_wr_en = 1; c_iter = 2;
        rd_d[0] = 10; rd_d[1] = 10; wr_d[0] = 6; wr_d[1] = 6;
        drive_run();
        checks++; if (obs_cyc !== 64'd24 || obs_iter !== 32'd2 || obs_err !== 2'b00) begin errors++;
            $display("FAIL dual got cyc=%0d iter=%0d err=%0d expected 24/2/0", obs_cyc, obs_iter, obs_err); end
        checks++; if (obs_rd !== 2 || obs_wr !== 2 || obs_done_cyc !== 25) begin errors++;
            $display("FAIL dual_starts got rd=%0d wr=%0d done_at=%0d expected 2/2/25", obs_rd, obs_wr, obs_done_cyc); end
    endtask

    task automatic test_zero_iter();
        clear_scenario();
        c_rd_en = 1; c_wr_en = 1; c_iter = 0;
        drive_run();
        checks++; if (obs_done_cyc !== 1 || obs_done_cnt !== 1) begin errors++;
            $display("FAIL zero_done got at=%0d count=%0d expected 1/1", obs_done_cyc, obs_done_cnt); end
        checks++; if (obs_rd !== 0 || obs_wr !== 0 || obs_iter !== 32'd0 || obs_cyc !== 64'd0) begin errors++;
            $display("FAIL zero_counts got rd=%0d wr=%0d iter=%0d cyc=%0d expected all 0", obs_rd, obs_wr, obs_iter, obs_cyc); end
    endtask

    task automatic test_timeout();
        clear_scenario();
        c_rd_en = 1; c_iter = 2; c_tmo = 8; rd_d[0] = 0;
        drive_run();
        checks++; if (obs_err !== 2'b10 || obs_iter !== 32'd0) begin errors++;
            $display("FAIL timeout got err=%0d iter=%0d expected 2/0", obs_err, obs_iter); end
        checks++; if (obs_cyc !== 64'd9 || obs_done_cyc !== 10 || obs_busy_after !== 0) begin errors++;
            $display("FAIL timeout_timing got cyc=%0d done_at=%0d busy_after=%0d expected 9/10/0", obs_cyc, obs_done_cyc, obs_busy_after); end
    endtask

    task automatic test_errors();
        clear_scenario();
        c_rd_en = 1; c_iter = 4; for (int i = 0; i < 4; i++) rd_d[i] = 5;
        f_kind = 1; f_iter = 1; f_cyc = 3;
        drive_run();
        checks++; if (obs_err !== 2'b01 || obs_iter !== 32'd1 || obs_cyc !== 64'd11) begin errors++;
            $display("FAIL data_error got err=%0d iter=%0d cyc=%0d expected 1/1/11", obs_err, obs_iter, obs_cyc); end
        clear_scenario();
        c_rd_en = 1; c_iter = 2; rd_d[0] = 6; rd_d[1] = 6;
        f_kind = 2; f_iter = 0; f_cyc = 6;   // abort on the rd_done cycle
        drive_run();
        checks++; if (obs_err !== 2'b11 || obs_iter !== 32'd0 || obs_cyc !== 64'd7) begin errors++;
            $display("FAIL abort_vs_done got err=%0d iter=%0d cyc=%0d expected 3/0/7", obs_err, obs_iter, obs_cyc); end
    endtask

    task automatic test_reset_mid_run();
        int stray;
        @(negedge clk);
        cfg_rd_en = 1; cfg_wr_en = 0; cfg_iter = 32'd5; cfg_timeout = '0; cfg_start = 1;
        @(negedge clk); cfg_start = 0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1 || cycle_cnt === 64'd0) begin errors++;
            $display("FAIL pre_reset_run got busy=%0d cyc=%0d expected busy=1 cyc>0", busy, cycle_cnt); end
        #2 resetn = 1'b0;
        #1;
        checks++; if ({busy, sched_done, rd_engine_start, wr_engine_start, err_code, iter_cnt, cycle_cnt} !== '0) begin errors++;
            $display("FAIL mid_reset got busy=%0d err=%0d iter=%0d cyc=%0d expected all 0", busy, err_code, iter_cnt, cycle_cnt); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || rd_engine_start || wr_engine_start) stray++;
        end
        checks++; if (stray !== 0) begin errors++;
            $display("FAIL post_reset_idle got %0d active cycles expected 0", stray); end
        clear_scenario();
        c_rd_en = 1; c_iter = 2; rd_d[0] = 4; rd_d[1] = 4; spur_cyc = 3;
        drive_run();
        checks++; if (obs_rd !== 2 || obs_wr !== 0 || obs_iter !== 32'd2 || obs_cyc !== 64'd12) begin errors++;
            $display("FAIL start_while_busy got rd=%0d wr=%0d iter=%0d cyc=%0d expected 2/0/2/12", obs_rd, obs_wr, obs_iter, obs_cyc); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            clear_scenario();
            c_rd_en = 1'($urandom_range(0, 1));
            c_wr_en = 1'($urandom_range(0, 1));
            if (r % 5 != 4 && !c_rd_en && !c_wr_en) c_rd_en = 1;
            c_iter = (r % 8 == 7) ? 0 : int'($urandom_range(1, 6));
            c_tmo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 14)) : 0;
            for (int i = 0; i < 8; i++) begin
                rd_d[i] = int'($urandom_range(1, 10));
                wr_d[i] = int'($urandom_range(1, 10));
                if (c_tmo != 0 && $urandom_range(0, 99) < 15) rd_d[i] = 0;
            end
            if ($urandom_range(0, 99) < 30 && c_iter > 0) begin
                f_kind = int'($urandom_range(1, 2));
                f_iter = int'($urandom_range(0, c_iter - 1));
                f_cyc = int'($urandom_range(0, 11));
            end
            compute_expected();
            drive_run();
            checks++; if (obs_iter !== 32'(exp_iter) || obs_err !== 2'(exp_err)) begin errors++;
                $display("FAIL rand%0d status got iter=%0d err=%0d expected iter=%0d err=%0d", r, obs_iter, obs_err, exp_iter, exp_err); end
            checks++; if (obs_cyc !== 64'(exp_cyc)) begin errors++;
                $display("FAIL rand%0d cycles got %0d expected %0d", r, obs_cyc, exp_cyc); end
            checks++; if (obs_rd !== exp_rd || obs_wr !== exp_wr) begin errors++;
                $display("FAIL rand%0d starts got rd=%0d wr=%0d expected rd=%0d wr=%0d", r, obs_rd, obs_wr, exp_rd, exp_wr); end
            checks++; if (obs_done_cnt !== 1 || obs_done_cyc !== int'(exp_cyc) + 1 || obs_busy_after !== 0) begin errors++;
                $display("FAIL rand%0d done got count=%0d at=%0d busy_after=%0d expected 1/%0d/0", r, obs_done_cnt, obs_done_cyc, obs_busy_after, exp_cyc + 1); end
        end
    endtask

`ifdef PERF_SCHED_LATENCY_EN
    task automatic test_latency();
        clear_scenario();
        c_rd_en = 1; c_iter = 3; rd_d[0] = 3; rd_d[1] = 7; rd_d[2] = 5;
        drive_run();
        checks++; if (lat_min !== 32'd3 || lat_max !== 32'd7) begin errors++;
            $display("FAIL latency got min=%0d max=%0d expected 3/7", lat_min, lat_max); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_rd();
        test_dual();
        test_zero_iter();
        test_timeout();
        test_errors();
        test_reset_mid_run();
        test_random();
`ifdef PERF_SCHED_LATENCY_EN
        test_latency();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
